// File: rtl/spi_rx_pkg.sv
// Shared definitions for the SPI receive shifter: line idle level and FSM states.
package spi_rx_pkg;

  localparam logic SPI_IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HUNT  = 2'd1,
    ST_SHIFT = 2'd2
  } rx_state_t;

endpackage

// File: rtl/spi_rx.sv
// SPI receive shifter: samples miso MSB-first on posedge sclk, with an optional
// hunt for the first 0 bit (SD-card style token) bounded by a timeout.
module spi_rx
  import spi_rx_pkg::*;
#(
  parameter int BitCount      = 8,
  parameter int BitCountLog2  = 4,
  parameter int TimeoutCycles = 255,
  parameter int TimeoutLog2   = 8
) (
  input  logic                sclk,
  input  logic                reset,
  input  logic                miso,
  input  logic                start,
  input  logic                wait_token,
  output logic [BitCount-1:0] data,
  output logic                busy,
  output logic                done,
  output logic                timeout
);

  localparam logic [BitCountLog2-1:0] BitLast  = BitCountLog2'(BitCount - 1);
  localparam logic [TimeoutLog2-1:0]  HuntLast = TimeoutLog2'(TimeoutCycles - 1);

  rx_state_t               state_q, state_d;
  logic [BitCount-1:0]     shift_q, shift_d;
  logic [BitCount-1:0]     shifted;
  logic [BitCountLog2-1:0] bitcnt_q, bitcnt_d;
  logic [TimeoutLog2-1:0]  huntcnt_q, huntcnt_d;
  logic [BitCount-1:0]     data_q, data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    timeout_q, timeout_d;
  logic                    accept;

  assign shifted = (shift_q << 1) | BitCount'(miso);

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      huntcnt_q <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      huntcnt_q <= huntcnt_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // Any running edge that does not finish clears done/timeout; a start is
  // accepted from idle or on the very edge a word completes (back-to-back).
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    huntcnt_d = huntcnt_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    accept    = 1'b0;

    case (state_q)
      ST_IDLE: accept = start;

      ST_HUNT: begin
        done_d    = 1'b0;
        timeout_d = 1'b0;
        if (miso != SPI_IDLE_LEVEL) begin
          shift_d  = shifted;
          bitcnt_d = BitCountLog2'(1);
          state_d  = ST_SHIFT;
          if (BitCount == 1) begin
            data_d   = shifted;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            bitcnt_d = '0;
            state_d  = ST_IDLE;
          end
        end else if (huntcnt_q == HuntLast) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          huntcnt_d = huntcnt_q + TimeoutLog2'(1);
        end
      end

      ST_SHIFT: begin
        done_d    = 1'b0;
        timeout_d = 1'b0;
        shift_d   = shifted;
        if (bitcnt_q == BitLast) begin
          data_d  = shifted;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
          accept  = start;
        end else begin
          bitcnt_d = bitcnt_q + BitCountLog2'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      busy_d    = 1'b1;
      timeout_d = 1'b0;
      bitcnt_d  = '0;
      huntcnt_d = '0;
      state_d   = wait_token ? ST_HUNT : ST_SHIFT;
      if (state_q == ST_IDLE) begin
        done_d = 1'b0;
      end
    end
  end

  assign data    = data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_spi_rx.sv
// Bench for spi_rx: a transaction-level model (bit queue, skip counter) checked
// every cycle, plus literal expectations at the end of each directed transfer.
module tb_spi_rx;

  localparam int BC = 8;
  localparam int TO = 16;

  logic       sclk = 1'b0;
  logic       reset;
  logic       miso;
  logic       start;
  logic       wait_token;
  logic [7:0] data;
  logic       busy;
  logic       done;
  logic       timeout;

  int tests_run    = 0;
  int tests_failed = 0;

  spi_rx #(
    .BitCount(BC),
    .BitCountLog2(4),
    .TimeoutCycles(TO),
    .TimeoutLog2(4)
  ) dut (
    .sclk(sclk),
    .reset(reset),
    .miso(miso),
    .start(start),
    .wait_token(wait_token),
    .data(data),
    .busy(busy),
    .done(done),
    .timeout(timeout)
  );

  always #5 sclk = ~sclk;

  bit         m_running;
  bit         m_hunting;
  bit         m_q[$];
  int         m_highs;
  logic [7:0] m_data;
  logic [7:0] m_word;
  bit         m_busy;
  bit         m_done;
  bit         m_timeout;

  task m_accept();
    m_running = 1'b1;
    m_busy    = 1'b1;
    m_timeout = 1'b0;
    m_hunting = wait_token;
    m_highs   = 0;
    m_q.delete();
  endtask

  // Model: a word is whatever bits were collected once the queue holds BC of them.
  always @(posedge sclk or posedge reset) begin
    if (reset) begin
      m_running = 1'b0;
      m_hunting = 1'b0;
      m_q.delete();
      m_highs   = 0;
      m_data    = '0;
      m_busy    = 1'b0;
      m_done    = 1'b0;
      m_timeout = 1'b0;
    end else if (!m_running) begin
      if (start) begin
        m_accept();
        m_done = 1'b0;
      end
    end else if (m_hunting) begin
      m_done    = 1'b0;
      m_timeout = 1'b0;
      if (miso == 1'b0) begin
        m_hunting = 1'b0;
        m_q.push_back(1'b0);
      end else begin
        m_highs++;
        if (m_highs == TO) begin
          m_running = 1'b0;
          m_busy    = 1'b0;
          m_done    = 1'b1;
          m_timeout = 1'b1;
        end
      end
    end else begin
      m_done    = 1'b0;
      m_timeout = 1'b0;
      m_q.push_back(miso);
      if (m_q.size() == BC) begin
        m_word = '0;
        foreach (m_q[i]) m_word = {m_word[6:0], m_q[i]};
        m_data    = m_word;
        m_done    = 1'b1;
        m_busy    = 1'b0;
        m_running = 1'b0;
        if (start) m_accept();
      end
    end
  end

  always @(posedge sclk) begin
    #2;
    if (!reset) begin
      tests_run++;
      if ({data, busy, done, timeout} !== {m_data, m_busy, m_done, m_timeout}) begin
        tests_failed++;
        $display("[TB] FAIL cycle_compare t=%0t: got data=%h busy=%b done=%b timeout=%b, want data=%h busy=%b done=%b timeout=%b",
                 $time, data, busy, done, timeout, m_data, m_busy, m_done, m_timeout);
      end
    end
  end

  task check_output(input string name, input logic [7:0] exp_data, input logic exp_busy,
                    input logic exp_done, input logic exp_timeout);
    tests_run++;
    if ({data, busy, done, timeout} !== {exp_data, exp_busy, exp_done, exp_timeout}) begin
      tests_failed++;
      $display("[TB] FAIL %s: got data=%h busy=%b done=%b timeout=%b, want data=%h busy=%b done=%b timeout=%b",
               name, data, busy, done, timeout, exp_data, exp_busy, exp_done, exp_timeout);
    end
  endtask

  // Starts a transfer, then drives `highs` idle bits and `nbits` of word MSB-first;
  // start is re-pulsed during bit index pulse_at (-1 for never).
  task apply_stimulus(input logic [7:0] word, input logic wt, input int highs,
                      input int nbits, input int pulse_at);
    @(negedge sclk);
    start      = 1'b1;
    wait_token = wt;
    miso       = 1'b1;
    @(negedge sclk);
    start      = 1'b0;
    wait_token = ~wt;
    for (int i = 0; i < highs; i++) begin
      miso = 1'b1;
      @(negedge sclk);
    end
    for (int i = 0; i < nbits; i++) begin
      miso  = word[7-i];
      start = (i == pulse_at);
      @(negedge sclk);
    end
    start      = 1'b0;
    wait_token = 1'b0;
    miso       = 1'b1;
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    wait_token = 1'b0;
    miso       = 1'b1;
    repeat (2) @(negedge sclk);
    check_output("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    apply_stimulus(8'hA5, 1'b0, 0, 8, -1);
    check_output("nowait_a5", 8'hA5, 1'b0, 1'b1, 1'b0);
    @(negedge sclk);
    check_output("idle_hold_a5", 8'hA5, 1'b0, 1'b1, 1'b0);

    apply_stimulus(8'h3C, 1'b1, 5, 8, -1);
    check_output("hunt5_3c", 8'h3C, 1'b0, 1'b1, 1'b0);

    apply_stimulus(8'h00, 1'b1, TO - 1, 0, -1);
    check_output("hunt_pre_timeout", 8'h3C, 1'b1, 1'b0, 1'b0);
    @(negedge sclk);
    check_output("hunt_timeout", 8'h3C, 1'b0, 1'b1, 1'b1);

    apply_stimulus(8'h4B, 1'b1, 0, 8, -1);
    check_output("hunt0_4b", 8'h4B, 1'b0, 1'b1, 1'b0);

    // Back-to-back: start held across the first completion edge.
    @(negedge sclk);
    start = 1'b1;
    @(negedge sclk);
    for (int i = 0; i < 8; i++) begin
      miso = (8'h12 >> (7 - i)) & 1'b1;
      @(negedge sclk);
    end
    check_output("b2b_first_12", 8'h12, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      miso  = (8'h34 >> (7 - i)) & 1'b1;
      start = 1'b0;
      @(negedge sclk);
    end
    miso = 1'b1;
    check_output("b2b_second_34", 8'h34, 1'b0, 1'b1, 1'b0);

    @(negedge sclk);
    start = 1'b1;
    @(negedge sclk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      miso = i[0];
      @(negedge sclk);
    end
    #2;
    reset = 1'b1;
    #1;
    check_output("async_reset_mid_shift", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge sclk);
    reset = 1'b0;
    miso  = 1'b1;

    apply_stimulus(8'hFF, 1'b0, 0, 8, -1);
    check_output("after_reset_ff", 8'hFF, 1'b0, 1'b1, 1'b0);

    apply_stimulus(8'h5A, 1'b0, 0, 8, 3);
    check_output("start_mid_shift_5a", 8'h5A, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge sclk);
    check_output("no_extra_transfer", 8'h5A, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
